// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline: load-use stalls, EX-stage
// redirect flushes, data-memory wait freezes and registered forwarding selects.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        ex_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        ex_mem_stall,
  output logic        id_ex_bubble,
  output logic        mem_wb_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_rs1,
  output logic [1:0]  fwd_rs2,
  output logic [1:0]  dbg_state,
  output logic [2:0]  dbg_shadow_valid,
  output logic [4:0]  dbg_ex_rd
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes;
    logic       is_load;
  } shadow_t;

  state_t  state;
  shadow_t sh_ex, sh_mem, sh_wb, id_sh;

  logic [4:0] id_rs1, id_rs2;
  logic       id_reads1, id_reads2, id_writes, id_is_load;
  logic       frozen, lu_hazard, redirect, load_ex;
  logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic [1:0] fwd1_next, fwd2_next;

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  always_comb begin
    id_writes  = 1'b0;
    id_is_load = 1'b0;
    id_reads1  = 1'b0;
    id_reads2  = 1'b0;
    case (id_inst[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: id_writes = 1'b1;
      7'b1100111: begin id_writes = 1'b1; id_reads1 = 1'b1; end
      7'b0000011: begin id_writes = 1'b1; id_reads1 = 1'b1; id_is_load = 1'b1; end
      7'b0010011: begin id_writes = 1'b1; id_reads1 = 1'b1; end
      7'b0110011: begin id_writes = 1'b1; id_reads1 = 1'b1; id_reads2 = 1'b1; end
      7'b0100011, 7'b1100011: begin id_reads1 = 1'b1; id_reads2 = 1'b1; end
      default: ;
    endcase
  end

  // A write to x0 is folded away here so no later comparison can match it.
  always_comb begin
    id_sh.valid   = 1'b1;
    id_sh.rd      = id_inst[11:7];
    id_sh.writes  = id_writes && (id_inst[11:7] != 5'd0);
    id_sh.is_load = id_is_load;
  end

  assign ex_hit1  = sh_ex.valid  && sh_ex.writes  && id_reads1 && (sh_ex.rd  == id_rs1);
  assign ex_hit2  = sh_ex.valid  && sh_ex.writes  && id_reads2 && (sh_ex.rd  == id_rs2);
  assign mem_hit1 = sh_mem.valid && sh_mem.writes && id_reads1 && (sh_mem.rd == id_rs1);
  assign mem_hit2 = sh_mem.valid && sh_mem.writes && id_reads2 && (sh_mem.rd == id_rs2);

  assign fwd1_next = ex_hit1 ? 2'b01 : (mem_hit1 ? 2'b10 : 2'b00);
  assign fwd2_next = ex_hit2 ? 2'b01 : (mem_hit2 ? 2'b10 : 2'b00);

  // Priority: memory wait freezes everything, then redirect, then load-use.
  assign frozen    = !mem_ready && (mem_req || (state == MEM_WAIT));
  assign redirect  = ex_taken && !frozen;
  assign lu_hazard = (state == RUN) && !frozen && !ex_taken && id_valid &&
                     sh_ex.valid && sh_ex.is_load && (ex_hit1 || ex_hit2);
  assign load_ex   = id_valid && !lu_hazard && !redirect;

  assign pc_stall      = frozen || lu_hazard;
  assign if_id_stall   = frozen || lu_hazard;
  assign ex_mem_stall  = frozen;
  assign id_ex_bubble  = lu_hazard;
  assign mem_wb_bubble = frozen;
  assign if_id_flush   = redirect;
  assign id_ex_flush   = redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      sh_ex   <= '0;
      sh_mem  <= '0;
      sh_wb   <= '0;
      fwd_rs1 <= 2'b00;
      fwd_rs2 <= 2'b00;
    end else begin
      if (frozen)         state <= MEM_WAIT;
      else if (lu_hazard) state <= LU_STALL;
      else                state <= RUN;

      if (!frozen) begin
        sh_wb  <= sh_mem;
        sh_mem <= sh_ex;
        if (load_ex) begin
          sh_ex   <= id_sh;
          fwd_rs1 <= fwd1_next;
          fwd_rs2 <= fwd2_next;
        end else begin
          sh_ex   <= '0;
          fwd_rs1 <= 2'b00;
          fwd_rs2 <= 2'b00;
        end
      end
    end
  end

  assign dbg_state        = state;
  assign dbg_shadow_valid = {sh_ex.valid, sh_mem.valid, sh_wb.valid};
  assign dbg_ex_rd        = sh_ex.rd;

  logic unused_bits;
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12], sh_mem.is_load,
                         sh_wb.rd, sh_wb.writes, sh_wb.is_load};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, redirect,
// memory wait and reset-during-wait scenarios with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk, rst, id_valid, ex_taken, mem_req, mem_ready;
  logic [31:0] id_inst;
  logic        pc_stall, if_id_stall, ex_mem_stall, id_ex_bubble, mem_wb_bubble;
  logic        if_id_flush, id_ex_flush;
  logic [1:0]  fwd_rs1, fwd_rs2, dbg_state;
  logic [2:0]  dbg_shadow_valid;
  logic [4:0]  dbg_ex_rd;
  logic [6:0]  ctl;
  logic [3:0]  fwd;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ADDI_X5      = 32'h0010_0293;
  localparam logic [31:0] ADDI_X5_2    = 32'h0020_0293;
  localparam logic [31:0] ADDI_X7      = 32'h0020_0393;
  localparam logic [31:0] ADD_X6_X5_X5 = 32'h0052_8333;
  localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] LW_X5        = 32'h0000_A283;
  localparam logic [31:0] ADD_X6_X5_X0 = 32'h0002_8333;
  localparam logic [31:0] ADDI_X0      = 32'h0010_0013;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;

  // ctl order: pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush
  localparam logic [6:0] CTL_IDLE  = 7'b000_0000;
  localparam logic [6:0] CTL_LU    = 7'b111_0000;
  localparam logic [6:0] CTL_WAIT  = 7'b110_1100;
  localparam logic [6:0] CTL_FLUSH = 7'b000_0011;

  assign ctl = {pc_stall, if_id_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble,
                if_id_flush, id_ex_flush};
  assign fwd = {fwd_rs1, fwd_rs2};

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .ex_taken(ex_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .ex_mem_stall(ex_mem_stall),
    .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .dbg_state(dbg_state),
    .dbg_shadow_valid(dbg_shadow_valid), .dbg_ex_rd(dbg_ex_rd)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic set_in(input logic v, input logic [31:0] inst, input logic tk,
                        input logic rq, input logic rdy);
    id_valid  = v;
    id_inst   = inst;
    ex_taken  = tk;
    mem_req   = rq;
    mem_ready = rdy;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    edge_step();
    edge_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_shadow_valid !== 3'b000) begin errors++; $display("FAIL reset_shadow got=%b exp=000", dbg_shadow_valid); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd); end
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
  endtask

  task automatic test_fwd_alu();
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL alu_ctl0 got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b1, ADD_X6_X5_X5, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL alu_ctl1 got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (fwd !== 4'b0101) begin errors++; $display("FAIL alu_fwd got=%b exp=0101", fwd); end
    checks++; if (dbg_ex_rd !== 5'd6) begin errors++; $display("FAIL alu_ex_rd got=%0d exp=6", dbg_ex_rd); end
    checks++; if (dbg_shadow_valid !== 3'b110) begin errors++; $display("FAIL alu_shadow got=%b exp=110", dbg_shadow_valid); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1'b1, LW_X5, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lu_ctl0 got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b1, ADD_X6_X5_X0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, CTL_LU); end
    edge_step();
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL lu_state got=%0d exp=1", dbg_state); end
    checks++; if (dbg_shadow_valid !== 3'b010) begin errors++; $display("FAIL lu_shadow got=%b exp=010", dbg_shadow_valid); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL lu_bubble_fwd got=%b exp=0000", fwd); end
    #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lu_second got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (fwd !== 4'b1000) begin errors++; $display("FAIL lu_fwd got=%b exp=1000", fwd); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL lu_back_run got=%0d exp=0", dbg_state); end
    checks++; if (dbg_shadow_valid !== 3'b101) begin errors++; $display("FAIL lu_shadow2 got=%b exp=101", dbg_shadow_valid); end
  endtask

  task automatic test_x0();
    do_reset();
    set_in(1'b1, ADDI_X0, 1'b0, 1'b0, 1'b1);
    edge_step();
    set_in(1'b1, ADD_X6_X0_X0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL x0_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL x0_fwd got=%b exp=0000", fwd); end
    checks++; if (dbg_shadow_valid !== 3'b110) begin errors++; $display("FAIL x0_shadow got=%b exp=110", dbg_shadow_valid); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1);   edge_step();
    set_in(1'b1, ADDI_X5_2, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADD_X6_X5_X5, 1'b0, 1'b0, 1'b1); edge_step();
    checks++; if (fwd !== 4'b0101) begin errors++; $display("FAIL prio_nearest got=%b exp=0101", fwd); end
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADDI_X7, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADD_X6_X5_X7, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (fwd !== 4'b1001) begin errors++; $display("FAIL prio_mixed got=%b exp=1001", fwd); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_in(1'b1, LW_X5, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADD_X6_X5_X0, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (ctl !== CTL_FLUSH) begin errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl, CTL_FLUSH); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (dbg_shadow_valid !== 3'b010) begin errors++; $display("FAIL redir_shadow got=%b exp=010", dbg_shadow_valid); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL redir_state got=%0d exp=0", dbg_state); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL redir_fwd got=%b exp=0000", fwd); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1);      edge_step();
    set_in(1'b1, ADD_X6_X5_X5, 1'b0, 1'b0, 1'b1); edge_step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, ADDI_X7, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (ctl !== CTL_WAIT) begin errors++; $display("FAIL wait_ctl[%0d] got=%b exp=%b", i, ctl, CTL_WAIT); end
      edge_step();
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL wait_state[%0d] got=%0d exp=2", i, dbg_state); end
      checks++; if ({dbg_shadow_valid, dbg_ex_rd, fwd} !== {3'b110, 5'd6, 4'b0101})
        begin errors++; $display("FAIL wait_hold[%0d] got=%b/%0d/%b exp=110/6/0101", i, dbg_shadow_valid, dbg_ex_rd, fwd); end
    end
    set_in(1'b1, ADDI_X7, 1'b0, 1'b1, 1'b1); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL wait_release got=%b exp=%b", ctl, CTL_IDLE); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL wait_run got=%0d exp=0", dbg_state); end
    checks++; if ({dbg_shadow_valid, dbg_ex_rd, fwd} !== {3'b111, 5'd7, 4'b0000})
      begin errors++; $display("FAIL wait_after got=%b/%0d/%b exp=111/7/0000", dbg_shadow_valid, dbg_ex_rd, fwd); end
  endtask

  task automatic test_wait_redirect();
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADDI_X7, 1'b1, 1'b1, 1'b0); #1;
    checks++; if (ctl !== CTL_WAIT) begin errors++; $display("FAIL wr_wait got=%b exp=%b", ctl, CTL_WAIT); end
    edge_step();
    set_in(1'b1, ADDI_X7, 1'b1, 1'b1, 1'b1); #1;
    checks++; if (ctl !== CTL_FLUSH) begin errors++; $display("FAIL wr_flush got=%b exp=%b", ctl, CTL_FLUSH); end
    edge_step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (dbg_shadow_valid !== 3'b010) begin errors++; $display("FAIL wr_shadow got=%b exp=010", dbg_shadow_valid); end
  endtask

  task automatic test_wait_reset();
    do_reset();
    set_in(1'b1, ADDI_X5, 1'b0, 1'b0, 1'b1); edge_step();
    set_in(1'b1, ADDI_X7, 1'b0, 1'b1, 1'b0); #1;
    checks++; if (ctl !== CTL_WAIT) begin errors++; $display("FAIL wrst_wait got=%b exp=%b", ctl, CTL_WAIT); end
    edge_step();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL wrst_state got=%0d exp=2", dbg_state); end
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    edge_step();
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL wrst_run got=%0d exp=0", dbg_state); end
    checks++; if ({ctl, fwd} !== 11'b0) begin errors++; $display("FAIL wrst_outs got=%b/%b exp=0/0", ctl, fwd); end
    checks++; if (dbg_shadow_valid !== 3'b000) begin errors++; $display("FAIL wrst_shadow got=%b exp=000", dbg_shadow_valid); end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_x0();
    test_fwd_priority();
    test_redirect();
    test_mem_wait();
    test_wait_redirect();
    test_wait_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
